// File: rtl/multichannel_bin_downsampler_pkg.sv
// Shared definitions for the multichannel bin downsampler: reduction modes,
// FSM states, accumulator sizing and per-channel slice helpers.
package multichannel_bin_downsampler_pkg;

  localparam logic [1:0] MODE_MEAN_TRUNC = 2'd0;
  localparam logic [1:0] MODE_MEAN_ROUND = 2'd1;
  localparam logic [1:0] MODE_MAX        = 2'd2;
  localparam logic [1:0] MODE_MIN        = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Wide enough to hold the sum of the largest bin without overflow.
  function automatic int acc_w(input int data_w, input int max_bw_log2, input int max_bh_log2);
    return data_w + max_bw_log2 + max_bh_log2;
  endfunction

  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/multichannel_bin_downsampler_if.sv
// Pixel-in / bin-out stream bundle; the downsampler uses the slave modport.
interface multichannel_bin_downsampler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3
);
  localparam int PIX_W = DATA_WIDTH * NUM_CHANNELS;

  logic             data_in_valid;
  logic             data_in_ready;
  logic [PIX_W-1:0] data_in;
  logic             sof_in;
  logic             data_out_valid;
  logic             data_out_ready;
  logic [PIX_W-1:0] data_out;
  logic             data_out_last;
  logic             frame_error;

  modport slave (
    input  data_in_valid, data_in, sof_in, data_out_ready,
    output data_in_ready, data_out_valid, data_out, data_out_last, frame_error
  );

  modport master (
    output data_in_valid, data_in, sof_in, data_out_ready,
    input  data_in_ready, data_out_valid, data_out, data_out_last, frame_error
  );
endinterface

// File: rtl/multichannel_bin_downsampler_bin_row_buffer.sv
// Row buffer of partial bin sums: one write port, combinational read so a
// bin's read-modify-write finishes in the cycle the beat is accepted.
module bin_row_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 42,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/multichannel_bin_downsampler.sv
// Raster-order image reducer: each bin_w x bin_h block becomes one value per
// channel (mean-trunc, mean-round, max or min), with a single-entry output register.
module multichannel_bin_downsampler
  import multichannel_bin_downsampler_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int MAX_BW_LOG2  = 3,
  parameter int MAX_BH_LOG2  = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [$clog2(MAX_BW_LOG2+1)-1:0]     cfg_bw_log2,
  input  logic [$clog2(MAX_BH_LOG2+1)-1:0]     cfg_bh_log2,
  input  logic [1:0]                           cfg_mode,
  multichannel_bin_downsampler_if.slave        bus_io
);
  localparam int ACC_W = acc_w(DATA_WIDTH, MAX_BW_LOG2, MAX_BH_LOG2);
  localparam int PIX_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int BUF_W = NUM_CHANNELS * ACC_W;
  localparam int XW    = $clog2(IMAGE_WIDTH);
  localparam int YW    = $clog2(IMAGE_HEIGHT);
  localparam int BWL_W = $clog2(MAX_BW_LOG2+1);
  localparam int BHL_W = $clog2(MAX_BH_LOG2+1);
  localparam int SH_W  = $clog2(MAX_BW_LOG2+MAX_BH_LOG2+1);

  function automatic logic [ACC_W-1:0] combine(input logic [1:0] mode,
                                               input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    case (mode)
      MODE_MAX: return (a > b) ? a : b;
      MODE_MIN: return (a < b) ? a : b;
      default:  return a + b;
    endcase
  endfunction

  // Max/min already fit DATA_WIDTH; a mean of DATA_WIDTH samples never exceeds it.
  function automatic logic [DATA_WIDTH-1:0] finalize(input logic [1:0] mode,
                                                     input logic [ACC_W-1:0] v,
                                                     input logic [SH_W-1:0] sh);
    logic [ACC_W-1:0] rnd;
    rnd = (sh == '0) ? '0 : (ACC_W'(1) << (sh - SH_W'(1)));
    case (mode)
      MODE_MEAN_TRUNC: return DATA_WIDTH'(v >> sh);
      MODE_MEAN_ROUND: return DATA_WIDTH'((v + rnd) >> sh);
      default:         return DATA_WIDTH'(v);
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [BWL_W-1:0]   bw_q, bw_d;
  logic [BHL_W-1:0]   bh_q, bh_d;
  logic [1:0]         mode_q, mode_d;
  logic [BUF_W-1:0]   h_acc_q, h_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [PIX_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               ferr_q, ferr_d;

  logic               in_ready, accept, sof, take;
  logic [BWL_W-1:0]   bw_e;
  logic [BHL_W-1:0]   bh_e;
  logic [1:0]         mode_e;
  logic [SH_W-1:0]    shift_e;
  logic [XW-1:0]      x_e, mask_w, row_addr;
  logic [YW-1:0]      y_e, mask_h;
  logic               x_first, x_last, y_first, y_last, frame_last;
  logic [BUF_W-1:0]   h_all, v_all, rd_data;
  logic [PIX_W-1:0]   res_all;

  // Beats arriving at sof use the incoming config and restart at pixel (0,0).
  assign in_ready   = !(out_valid_q && !bus_io.data_out_ready);
  assign accept     = bus_io.data_in_valid && in_ready;
  assign sof        = bus_io.sof_in;
  assign take       = accept && (sof || state_q == ST_ACTIVE);
  assign bw_e       = sof ? cfg_bw_log2 : bw_q;
  assign bh_e       = sof ? cfg_bh_log2 : bh_q;
  assign mode_e     = sof ? cfg_mode    : mode_q;
  assign shift_e    = SH_W'(bw_e) + SH_W'(bh_e);
  assign x_e        = sof ? '0 : x_q;
  assign y_e        = sof ? '0 : y_q;
  assign mask_w     = ~({XW{1'b1}} << bw_e);
  assign mask_h     = ~({YW{1'b1}} << bh_e);
  assign x_first    = (x_e & mask_w) == '0;
  assign x_last     = (x_e & mask_w) == mask_w;
  assign y_first    = (y_e & mask_h) == '0;
  assign y_last     = (y_e & mask_h) == mask_h;
  assign frame_last = (x_e == XW'(IMAGE_WIDTH-1)) && (y_e == YW'(IMAGE_HEIGHT-1));
  assign row_addr   = x_e >> bw_e;

  always_comb begin
    h_all   = '0;
    v_all   = '0;
    res_all = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      logic [ACC_W-1:0] pix_c, h_c, v_c;
      pix_c = ACC_W'(bus_io.data_in[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]);
      h_c   = x_first ? pix_c : combine(mode_e, h_acc_q[ch_lsb(c, ACC_W) +: ACC_W], pix_c);
      v_c   = y_first ? h_c : combine(mode_e, rd_data[ch_lsb(c, ACC_W) +: ACC_W], h_c);
      h_all[ch_lsb(c, ACC_W) +: ACC_W]        = h_c;
      v_all[ch_lsb(c, ACC_W) +: ACC_W]        = v_c;
      res_all[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH] = finalize(mode_e, v_c, shift_e);
    end
  end

  bin_row_buffer #(
    .DEPTH (IMAGE_WIDTH),
    .WIDTH (BUF_W)
  ) u_row_buf (
    .clock     (clock),
    .wr_en_i   (take && x_last),
    .wr_addr_i (row_addr),
    .wr_data_i (v_all),
    .rd_addr_i (row_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bw_d        = bw_q;
    bh_d        = bh_q;
    mode_d      = mode_q;
    h_acc_d     = h_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ferr_d      = accept && (sof ? (state_q == ST_ACTIVE) : (state_q == ST_IDLE));
    if (take) begin
      state_d = frame_last ? ST_IDLE : ST_ACTIVE;
      bw_d    = bw_e;
      bh_d    = bh_e;
      mode_d  = mode_e;
      h_acc_d = h_all;
      if (x_e == XW'(IMAGE_WIDTH-1)) begin
        x_d = '0;
        y_d = (y_e == YW'(IMAGE_HEIGHT-1)) ? '0 : y_e + YW'(1);
      end else begin
        x_d = x_e + XW'(1);
        y_d = y_e;
      end
    end
    if (take && x_last && y_last) begin
      out_valid_d = 1'b1;
      out_data_d  = res_all;
      out_last_d  = frame_last;
    end else if (bus_io.data_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      bw_q        <= BWL_W'(2);
      bh_q        <= BHL_W'(3);
      mode_q      <= MODE_MEAN_TRUNC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bw_q        <= bw_d;
      bh_q        <= bh_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      ferr_q      <= ferr_d;
    end
  end

  always_ff @(posedge clock) begin
    h_acc_q <= h_acc_d;
  end

  assign bus_io.data_in_ready  = in_ready;
  assign bus_io.data_out_valid = out_valid_q;
  assign bus_io.data_out       = out_data_q;
  assign bus_io.data_out_last  = out_last_q;
  assign bus_io.frame_error    = ferr_q;
endmodule

// File: tb/tb_multichannel_bin_downsampler.sv
// Directed bench for the bin downsampler on an 8x4, 3-channel image.
module tb_multichannel_bin_downsampler;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] cfg_bw_log2, cfg_bh_log2, cfg_mode;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  logic [24:0] outq [$];

  multichannel_bin_downsampler_if #(.DATA_WIDTH(8), .NUM_CHANNELS(3)) bus ();

  multichannel_bin_downsampler #(
    .DATA_WIDTH(8), .NUM_CHANNELS(3), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4),
    .MAX_BW_LOG2(3), .MAX_BH_LOG2(3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_bw_log2 (cfg_bw_log2),
    .cfg_bh_log2 (cfg_bh_log2),
    .cfg_mode    (cfg_mode),
    .bus_io      (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && bus.data_out_valid && bus.data_out_ready)
      outq.push_back({bus.data_out_last, bus.data_out});
    if (bus.frame_error) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] pix, input logic sof);
    int guard;
    guard = 0;
    @(negedge clock);
    bus.data_in_valid = 1'b1;
    bus.data_in       = pix;
    bus.sof_in        = sof;
    while (!bus.data_in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("in_ready_wait", 32'(bus.data_in_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.data_in_valid = 1'b0;
    bus.sof_in        = 1'b0;
  endtask

  function automatic logic [7:0] pv(input int seed, input int x, input int y, input int c);
    return 8'((x * 17 + y * 29 + c * 50 + seed) & 255);
  endfunction

  function automatic logic [23:0] pixw(input int seed, input int x, input int y);
    return {pv(seed, x, y, 2), pv(seed, x, y, 1), pv(seed, x, y, 0)};
  endfunction

  function automatic logic [23:0] mean2x2(input int seed, input int bx, input int by);
    logic [23:0] r;
    int s;
    for (int c = 0; c < 3; c++) begin
      s = pv(seed, 2*bx, 2*by, c) + pv(seed, 2*bx+1, 2*by, c)
        + pv(seed, 2*bx, 2*by+1, c) + pv(seed, 2*bx+1, 2*by+1, c);
      r[c*8 +: 8] = 8'(s / 4);
    end
    return r;
  endfunction

  function automatic logic [23:0] t2pix(input int x, input int y);
    logic [7:0] c0;
    if (x < 2 && y < 2)      c0 = (x == 0 && y == 0) ? 8'd1 : 8'd2;
    else if (x < 4 && y < 2) c0 = 8'd255;
    else                     c0 = 8'd7;
    return {8'd255, 8'd0, c0};
  endfunction

  task automatic check_model_frame(input string tag, input int seed);
    chk({tag, "_count"}, 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < outq.size()) begin
        chk({tag, "_data"}, 32'(outq[k][23:0]), 32'(mean2x2(seed, k % 4, k / 4)));
        chk({tag, "_last"}, 32'(outq[k][24]), 32'(k == 7));
      end
    end
  endtask

  task automatic stall_checks(input logic [23:0] exp);
    repeat (5) begin
      @(negedge clock);
      chk("stall_in_ready", 32'(bus.data_in_ready), 32'd0);
      chk("stall_valid", 32'(bus.data_out_valid), 32'd1);
      chk("stall_data", 32'(bus.data_out), 32'(exp));
    end
    @(posedge clock);
    #1 bus.data_out_ready = 1'b1;
  endtask

  logic [7:0] t2_exp [4];
  int fe0;

  initial begin
    t2_exp[0] = 8'd1; t2_exp[1] = 8'd2; t2_exp[2] = 8'd2; t2_exp[3] = 8'd1;
    reset = 1'b0;
    bus.data_in_valid = 1'b0; bus.data_in = '0; bus.sof_in = 1'b0;
    bus.data_out_ready = 1'b1;
    cfg_bw_log2 = 2'd1; cfg_bh_log2 = 2'd1; cfg_mode = 2'd0;
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_last", 32'(bus.data_out_last), 32'd0);
    chk("rst_ferr", 32'(bus.frame_error), 32'd0);
    chk("rst_in_ready", 32'(bus.data_in_ready), 32'd1);
    reset = 1'b1;

    // Constant pixel frame, 2x2 mean-trunc.
    for (int i = 0; i < 32; i++) send({8'd30, 8'd20, 8'd10}, i == 0);
    repeat (4) @(negedge clock);
    chk("const_count", 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < outq.size()) chk("const_out", 32'(outq[k]), {7'd0, (k == 7), 24'h1e140a});
    outq.delete();

    // Bin 1,2,2,2 / 255 in each mode.
    for (int m = 0; m < 4; m++) begin
      cfg_mode = 2'(m);
      for (int i = 0; i < 32; i++) send(t2pix(i % 8, i / 8), i == 0);
      repeat (4) @(negedge clock);
      chk("mode_count", 32'(outq.size()), 32'd8);
      if (outq.size() == 8) begin
        chk("mode_bin0", 32'(outq[0]), 32'({1'b0, 8'd255, 8'd0, t2_exp[m]}));
        chk("mode_bin1", 32'(outq[1]), 32'({1'b0, 8'd255, 8'd0, 8'd255}));
        chk("mode_bin7", 32'(outq[7]), 32'({1'b1, 8'd255, 8'd0, 8'd7}));
      end
      outq.delete();
    end
    chk("no_ferr_yet", 32'(fe_cnt), 32'd0);

    // Valid gaps, output stall at bin 0, config change mid-frame ignored.
    cfg_mode = 2'd0;
    for (int i = 0; i < 32; i++) begin
      if (i == 9) bus.data_out_ready = 1'b0;
      if (i == 10) begin
        fork
          send(pixw(1, i % 8, i / 8), 1'b0);
          stall_checks(mean2x2(1, 0, 0));
        join
      end else begin
        send(pixw(1, i % 8, i / 8), i == 0);
      end
      if (i == 0) begin cfg_mode = 2'd3; cfg_bw_log2 = 2'd0; end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    check_model_frame("gap", 1);
    outq.delete();

    // Aborted frame then restart at 4x4 max.
    cfg_bw_log2 = 2'd2; cfg_bh_log2 = 2'd2; cfg_mode = 2'd2;
    fe0 = fe_cnt;
    for (int i = 0; i < 13; i++) send({8'd200, 8'd200, 8'd200}, i == 0);
    for (int i = 0; i < 32; i++)
      send({8'((i%8)*3 + (i/8)*5 + 14), 8'((i%8)*3 + (i/8)*5 + 7), 8'((i%8)*3 + (i/8)*5)}, i == 0);
    repeat (4) @(negedge clock);
    chk("abort_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("abort_count", 32'(outq.size()), 32'd2);
    if (outq.size() == 2) begin
      chk("abort_bin0", 32'(outq[0]), 32'({1'b0, 8'd38, 8'd31, 8'd24}));
      chk("abort_bin1", 32'(outq[1]), 32'({1'b1, 8'd50, 8'd43, 8'd36}));
    end
    outq.delete();

    // Beats without sof while idle.
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) send(24'h0a0b0c, 1'b0);
    repeat (4) @(negedge clock);
    chk("nosof_ferr", 32'(fe_cnt - fe0), 32'd5);
    chk("nosof_count", 32'(outq.size()), 32'd0);

    // Reset mid-frame, then a clean frame.
    cfg_bw_log2 = 2'd1; cfg_bh_log2 = 2'd1; cfg_mode = 2'd0;
    for (int i = 0; i < 9; i++) send({8'd250, 8'd250, 8'd250}, i == 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_valid", 32'(bus.data_out_valid), 32'd0);
      chk("mid_rst_data", 32'(bus.data_out), 32'd0);
      chk("mid_rst_last", 32'(bus.data_out_last), 32'd0);
      chk("mid_rst_ferr", 32'(bus.frame_error), 32'd0);
    end
    reset = 1'b1;
    outq.delete();
    for (int i = 0; i < 32; i++) send(pixw(2, i % 8, i / 8), i == 0);
    repeat (4) @(negedge clock);
    check_model_frame("post_rst", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multichannel_bin_downsampler.md
Name: multichannel_bin_downsampler

Overview:
Streaming raster-order image reducer that replaces each bin_w x bin_h pixel block with one value per colour channel. It is the parametrised successor of grayscale_downsampler and adds the following:
- N channels packed per beat.
- Bin size configurable at run time (power of two), latched at start of frame.
- Four reduction modes: mean-truncate, mean-round, max, min.
- Output backpressure and start-of-frame resynchronisation.
It sits between the camera/pixel front end and the feature/histogram stages.

Parameters:
DATA_WIDTH, 8, bits per channel sample
NUM_CHANNELS, 3, channels packed in data_in/data_out, channel 0 in LSBs
IMAGE_WIDTH, 320, pixels per line; a multiple of every supported bin width
IMAGE_HEIGHT, 240, lines per frame; a multiple of every supported bin height
MAX_BW_LOG2, 3, largest log2 bin width supported
MAX_BH_LOG2, 3, largest log2 bin height supported

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
cfg_bw_log2  in  $clog2(MAX_BW_LOG2+1)  log2 bin width, sampled on accepted sof beat
cfg_bh_log2  in  $clog2(MAX_BH_LOG2+1)  log2 bin height, sampled on accepted sof beat
cfg_mode  in  2  0 mean-trunc, 1 mean-round-half-up, 2 max, 3 min; sampled on accepted sof beat
data_in_valid  in  1  input beat valid
data_in_ready  out  1  input beat accepted when valid&&ready
data_in  in  NUM_CHANNELS*DATA_WIDTH  packed pixel
sof_in  in  1  marks first pixel of frame (qualified by valid&&ready)
data_out_valid  out  1  bin result valid
data_out_ready  in  1  downstream accept
data_out  out  NUM_CHANNELS*DATA_WIDTH  packed bin result
data_out_last  out  1  with data_out_valid: last bin of frame
frame_error  out  1  one-cycle pulse: sof seen mid-frame, or beat arrived with no sof

Behaviour:
- Reset (reset==0 at clock edge) has the following effects:
  - data_out_valid=0, data_out=0, data_out_last=0, frame_error=0, data_in_ready=1.
  - Counters cleared; FSM goes to IDLE.
  - Config regs reset to bw=2, bh=3 (4x8), mode 0.
  - Reset mid-frame discards all partial sums; the next frame needs sof_in.
- FSM has two states, IDLE and ACTIVE:
  - IDLE: beats without sof_in are dropped and pulse frame_error. A beat with sof_in latches the config, is processed as pixel (0,0), and moves the FSM to ACTIVE.
  - ACTIVE: on the final pixel of a frame, return to IDLE after the output is produced.
  - ACTIVE with sof_in: pulse frame_error, drop partial state, restart the frame at this beat with the new config. No output is emitted for the aborted frame.
- Counters: x in [0,IMAGE_WIDTH), y in [0,IMAGE_HEIGHT). Intra-bin x/y are taken from the low bits of x/y, masked by the latched log2 values.
- Horizontal accumulation: per channel, h_acc sums (or takes max/min of) bin_w consecutive accepted pixels.
- Vertical accumulation: at the last pixel of a bin row, the h_acc result is combined into row-buffer entry x>>bw:
  - first row of the bin band: write;
  - otherwise: read-modify-write.
- Accumulator width ACC_W = DATA_WIDTH+MAX_BW_LOG2+MAX_BH_LOG2; it must never overflow.
- Bin completion: on the last pixel of the last row of a bin, compute the result per channel:
  - mode 0: sum>>(bw+bh);
  - mode 1: (sum+(1<<(bw+bh-1)))>>(bw+bh); for a 1x1 bin the rounding term is 0;
  - mode 2/3: max/min value.
- Result width: the result fits DATA_WIDTH with no saturation needed.
- Output latency: data_out_valid asserts the cycle after the completing beat is accepted.
- data_out_last=1 only for bin index (IMAGE_WIDTH>>bw)*(IMAGE_HEIGHT>>bh)-1.
- Output register is single-entry:
  - data_out and data_out_last hold stable while valid&&!ready;
  - valid drops after the handshake unless a new result loads the same cycle.
- Input backpressure: data_in_ready = !(data_out_valid && !data_out_ready). It is registered-free combinational; there is no combinational path from data_in_valid to data_in_ready.
- Bins are emitted in bin-raster order. Channels are independent; there is no cross-channel carry.
- Config changes while ACTIVE are ignored until the next sof.

Decomposition:
- Package/include downsampler_defs provides:
  - mode constants MODE_MEAN_TRUNC/MODE_MEAN_ROUND/MODE_MAX/MODE_MIN;
  - the ACC_W function;
  - channel slice helpers.
- Sub-module bin_row_buffer holds the row buffer: IMAGE_WIDTH entries x NUM_CHANNELS*ACC_W bits, one write port, one read port. Its read is combinational or prefetched such that a bin's read-modify-write completes without stalling the input.
- The top level holds the counters, FSM, h_acc, combine/divide logic and the output register.

Test Plan:
- All tests use IMAGE 8x4, 3 channels, bin 2x2, mode 0.
- Constant pixel (10,20,30) every cycle -> exactly 8 outputs of (10,20,30); last asserted only on the 8th.
- Bin pixels 1,2,2,2 on ch0: mode 0 -> 1, mode 1 -> 2, mode 2 -> 2, mode 3 -> 1. Pixels 255x4 -> 255 in all modes.
- Random valid gaps plus data_out_ready held low 5 cycles at a bin end:
  - data_in_ready drops;
  - data_out stays stable;
  - no output is lost or duplicated;
  - results match the software model.
- sof mid-frame at pixel 13, then a full frame at 4x4 bins, mode 2:
  - frame_error pulses once;
  - exactly 2 outputs, each equal to the max of its bin.
- Beats with no preceding sof: all dropped, frame_error pulses per beat, no outputs.
- Reset asserted (low) mid-frame, then a clean frame: no stale sums; outputs equal the software model; all outputs 0 during reset.
